// File: rtl/spi_frame_ctrl_if.sv
// DSP-side word handshake bundle for spi_frame_ctrl.
// The controller drives the master side; the DSP datapath uses the slave side.
interface spi_frame_ctrl_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [WORD_W-1:0] tx_data;
    logic              tx_load;
    logic              overrun;
    logic              ovr_clr;

    modport master (
        output rx_data, rx_valid, tx_load, overrun,
        input  rx_ready, tx_data, ovr_clr
    );

    modport slave (
        input  rx_data, rx_valid, tx_load, overrun,
        output rx_ready, tx_data, ovr_clr
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave framing controller: synchronizes SCK/SS/MOSI, frames bits
// into words, drives MISO from a shadowed tx word, hands words to the DSP.
module spi_frame_ctrl #(
    parameter int WORD_BYTES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic SCK,
    input  logic SS,
    input  logic MOSI,
    output logic MISO,
    output logic SSPIF,
    output logic busy,
    spi_frame_ctrl_if.master bus
);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
    logic                   sck_d, ss_d;
    logic [SYNC_STAGES:0]   flush;
    logic                   armed;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, ss_fall, ss_rise;

    logic                   start, abort, rise, fall;
    logic                   word_done, byte_done;

    logic [CW-1:0]          bit_cnt;
    logic [WORD_W-2:0]      rx_shift;
    logic [WORD_W-1:0]      tx_shadow;

    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign ss_s   = ss_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ~ss_s & ss_d & armed;
    assign ss_rise  = ss_s & ~ss_d;

    // Pin synchronizers, edge-detect copies, and a post-reset arm: a frame
    // may only start after SS has been seen high with real pin data.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sck_q  <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
            sck_d  <= 1'b0;
            ss_d   <= 1'b1;
            flush  <= '0;
            armed  <= 1'b0;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], SCK};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], SS};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            sck_d  <= sck_s;
            ss_d   <= ss_s;
            flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && ss_s) begin
                armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: SS framing alone moves between IDLE and SHIFT.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: if (abort) state_nx = IDLE;
        endcase
    end

    // FSM outputs: per-cycle strobes; ss_rise masks a coincident SCK edge.
    always_comb begin
        start = 1'b0;
        abort = 1'b0;
        rise  = 1'b0;
        fall  = 1'b0;
        busy  = 1'b0;
        unique case (state)
            IDLE: start = ss_fall;
            SHIFT: begin
                busy  = ~ss_s;
                abort = ss_rise;
                rise  = sck_rise & ~ss_rise;
                fall  = sck_fall & ~ss_rise;
            end
        endcase
        word_done = rise && (bit_cnt == LAST);
        byte_done = rise && (bit_cnt[2:0] == 3'd7);
    end

    // Bit datapath: shift registers, bit counter, MISO and tx reloads.
    // tx_shadow holds the bits still to send after the one on MISO, except
    // right after a word boundary where it holds the whole next word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shadow <= '0;
            MISO      <= 1'b0;
            SSPIF     <= 1'b0;
            bus.tx_load <= 1'b0;
        end else begin
            SSPIF       <= byte_done;
            bus.tx_load <= start | word_done;
            if (start) begin
                tx_shadow <= bus.tx_data << 1;
                MISO      <= bus.tx_data[WORD_W-1];
                bit_cnt   <= '0;
            end else if (abort) begin
                MISO    <= 1'b0;
                bit_cnt <= '0;
            end else if (rise) begin
                rx_shift <= {rx_shift[WORD_W-3:0], mosi_s};
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) begin
                    tx_shadow <= bus.tx_data;
                end
            end else if (fall) begin
                MISO      <= tx_shadow[WORD_W-1];
                tx_shadow <= tx_shadow << 1;
            end
        end
    end

    // Word handoff to the DSP with overrun tracking; a drop beats ovr_clr.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            if (word_done && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data  <= {rx_shift, mosi_s};
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
            if (word_done && bus.rx_valid && !bus.rx_ready) begin
                bus.overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                bus.overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: the bench acts as SPI master,
// queues expected delivered words, and a monitor checks each new rx word.
module tb_spi_frame_ctrl;
    localparam int W    = 16;
    localparam int HALF = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic SCK = 1'b0;
    logic SS  = 1'b1;
    logic MOSI = 1'b0;
    logic MISO, SSPIF, busy;

    spi_frame_ctrl_if #(.WORD_W(W)) bus ();

    spi_frame_ctrl #(.WORD_BYTES(2), .SYNC_STAGES(2)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .SCK   (SCK),
        .SS    (SS),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .SSPIF (SSPIF),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int n_load = 0;
    int n_sspif = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic pv = 1'b0;
    logic pr = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: a new word is present when rx_valid rises or stays up
    // across a handshake; pop the scoreboard and compare.
    always @(negedge Clk) begin
        if (Rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (bus.tx_load) n_load++;
            if (SSPIF) n_sspif++;
            if (bus.rx_valid && (!pv || pr)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_word: got %h, required none", bus.rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.rx_data !== mon_exp) begin
                        miscompares++;
                        $display("FAIL rx_word: got %h, required %h",
                                 bus.rx_data, mon_exp);
                    end
                end
            end
            pv = bus.rx_valid;
            pr = bus.rx_ready;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic ss_begin(input logic [W-1:0] tx);
        bus.tx_data = tx;
        SS = 1'b0;
        cyc(16);
    endtask

    task automatic ss_end();
        cyc(HALF);
        SS = 1'b1;
        cyc(24);
    endtask

    task automatic consume();
        bus.rx_ready = 1'b1;
        cyc(1);
        bus.rx_ready = 1'b0;
        cyc(1);
    endtask

    // Shift nbits of w MSB first; MISO is sampled just before each rise.
    task automatic send_bits(input logic [W-1:0] w, input int nbits,
                             input logic [W-1:0] exp_tx,
                             input logic [W-1:0] next_tx,
                             input bit ready_pulse);
        logic [W-1:0] got;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[W-1-i];
            cyc(HALF);
            got[W-1-i] = MISO;
            SCK = 1'b1;
            if (i == 0) bus.tx_data = next_tx;
            if (ready_pulse && i == nbits - 1) begin
                cyc(2);
                bus.rx_ready = 1'b1;
                cyc(1);
                bus.rx_ready = 1'b0;
                cyc(HALF - 3);
            end else begin
                cyc(HALF);
            end
            SCK = 1'b0;
        end
        if (nbits == W) check("miso_word", {16'h0, got}, {16'h0, exp_tx});
    endtask

    initial begin
        int l0, s0;
        logic [W-1:0] w1, w2, t1, t2, t3;
        bus.rx_ready = 1'b0;
        bus.tx_data  = '0;
        bus.ovr_clr  = 1'b0;
        cyc(4);
        Rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            check("idle_outputs",
                  {10'h0, MISO, SSPIF, bus.rx_valid, bus.tx_load,
                   bus.overrun, busy, bus.rx_data}, 32'h0);
            cyc(1);
        end

        l0 = n_load;
        s0 = n_sspif;
        ss_begin(16'h8001);
        check("busy_in_frame", {31'h0, busy}, 32'h1);
        exp_q.push_back(16'hA53C);
        send_bits(16'hA53C, 16, 16'h8001, 16'h0000, 1'b0);
        ss_end();
        check("sspif_count", n_sspif - s0, 2);
        check("tx_load_count", n_load - l0, 2);
        check("rx_valid_held", {31'h0, bus.rx_valid}, 32'h1);
        check("rx_data_a53c", {16'h0, bus.rx_data}, 32'hA53C);
        check("busy_after", {31'h0, busy}, 32'h0);
        consume();
        check("rx_valid_consumed", {31'h0, bus.rx_valid}, 32'h0);

        for (int k = 0; k < 3; k++) begin
            w1 = (k == 0) ? 16'h1234 : W'($urandom);
            w2 = (k == 0) ? 16'h5678 : W'($urandom);
            t1 = W'($urandom);
            t2 = W'($urandom);
            t3 = W'($urandom);
            l0 = n_load;
            s0 = n_sspif;
            ss_begin(t1);
            exp_q.push_back(w1);
            send_bits(w1, 16, t1, t2, 1'b0);
            send_bits(w2, 16, t2, t3, 1'b0);
            ss_end();
            check("overrun_set", {31'h0, bus.overrun}, 32'h1);
            check("rx_data_kept", {16'h0, bus.rx_data}, {16'h0, w1});
            check("b2b_tx_load_count", n_load - l0, 3);
            check("b2b_sspif_count", n_sspif - s0, 4);
            bus.ovr_clr = 1'b1;
            cyc(1);
            bus.ovr_clr = 1'b0;
            cyc(1);
            check("overrun_cleared", {31'h0, bus.overrun}, 32'h0);
            consume();

            ss_begin(t1);
            exp_q.push_back(w1);
            exp_q.push_back(w2);
            send_bits(w1, 16, t1, t2, 1'b0);
            send_bits(w2, 16, t2, t3, 1'b1);
            ss_end();
            check("no_overrun", {31'h0, bus.overrun}, 32'h0);
            check("rx_valid_stays", {31'h0, bus.rx_valid}, 32'h1);
            check("rx_data_second", {16'h0, bus.rx_data}, {16'h0, w2});
            consume();
        end

        s0 = n_sspif;
        ss_begin(16'hFFFF);
        send_bits(W'($urandom), 11, 16'h0, 16'h0, 1'b0);
        ss_end();
        check("abort_no_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("abort_sspif", n_sspif - s0, 1);
        ss_begin(16'h1111);
        exp_q.push_back(16'hBEEF);
        send_bits(16'hBEEF, 16, 16'h1111, 16'h2222, 1'b0);
        ss_end();
        check("rx_data_beef", {16'h0, bus.rx_data}, 32'hBEEF);
        cyc(2);

        ss_begin(16'h3333);
        send_bits(W'($urandom), 5, 16'h0, 16'h0, 1'b0);
        Rst = 1'b1;
        cyc(2);
        Rst = 1'b0;
        l0 = n_load;
        s0 = n_sspif;
        for (int i = 0; i < 16; i++) begin
            MOSI = 1'($urandom);
            cyc(HALF);
            SCK = 1'b1;
            cyc(HALF);
            SCK = 1'b0;
        end
        cyc(HALF);
        check("post_rst_outputs",
              {10'h0, MISO, SSPIF, bus.rx_valid, bus.tx_load,
               bus.overrun, busy, bus.rx_data}, 32'h0);
        check("post_rst_no_load", n_load - l0, 0);
        check("post_rst_no_sspif", n_sspif - s0, 0);
        SS = 1'b1;
        cyc(24);
        ss_begin(16'h0F0F);
        exp_q.push_back(16'h00FF);
        send_bits(16'h00FF, 16, 16'h0F0F, 16'h0000, 1'b0);
        ss_end();
        check("rx_data_00ff", {16'h0, bus.rx_data}, 32'h00FF);
        consume();

        bus.rx_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w1 = W'($urandom);
            t1 = W'($urandom);
            ss_begin(t1);
            exp_q.push_back(w1);
            send_bits(w1, 16, t1, W'($urandom), 1'b0);
            ss_end();
            check("rand_consumed", {31'h0, bus.rx_valid}, 32'h0);
        end
        bus.rx_ready = 1'b0;
        cyc(4);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Sequencing controller for the SPI slave receive and transmit path of the ANC board interface. It synchronizes the external SCK, SS and MOSI lines into the system clock domain and detects SCK edges. It counts bits, frames them into bytes and multi-byte sample words, and drives MISO from a shadowed transmit word. Completed words go to the DSP datapath through a valid/ready handshake, with overrun detection.

## Interface
Parameters:
- WORD_BYTES, 2, bytes per sample word; WORD_W = 8*WORD_BYTES
- SYNC_STAGES, 2, flip-flop stages on SCK/SS/MOSI (min 2)

Ports:
- Clk  in  1  system clock; single clock domain, all logic on rising edge
- Rst  in  1  reset, synchronous, active-high
- SCK  in  1  SPI clock, asynchronous to Clk, mode 0 (CPOL=0, CPHA=0)
- SS  in  1  slave select, active-low, asynchronous
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first
- SSPIF  out  1  one-Clk pulse per completed byte
- rx_data  out  WORD_W  last completed word; first received bit is rx_data[WORD_W-1]
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts rx_data
- tx_data  in  WORD_W  word to transmit next
- tx_load  out  1  one-Clk pulse: tx_data captured into tx shadow
- overrun  out  1  sticky: a word was dropped
- ovr_clr  in  1  clears overrun
- busy  out  1  SS active (synchronized) and FSM not IDLE

## Operation
- SCK, SS and MOSI each pass through SYNC_STAGES flops. One extra registered copy of SCK and SS provides edge detection: sck_rise, sck_fall, ss_fall, ss_rise.
- FSM states: IDLE and SHIFT.
  - IDLE: MISO=0, bit_cnt=0. On ss_fall: capture tx_data into tx_shadow, pulse tx_load, MISO=tx_shadow MSB, go to SHIFT.
  - SHIFT, on sck_rise: rx_shift <= {rx_shift[WORD_W-2:0], MOSI_sync}; bit_cnt++.
  - SHIFT, on sck_fall: tx_shadow shifts left, and MISO takes the new MSB.
  - SHIFT, ss_rise (any bit_cnt): go to IDLE, discard the partial word, bit_cnt=0, no rx_valid and no SSPIF for the partial byte. ss_rise has priority over a coincident sck edge.
- Byte boundary: when an sck_rise makes bit_cnt[2:0] wrap to 0, pulse SSPIF in the following cycle.
- Word boundary: bit_cnt counts 0..WORD_W-1 and wraps to 0 on the WORD_W-th sck_rise. At that point the word completes:
  - if rx_valid=0, or rx_ready=1 in the same cycle: rx_data <= assembled word, rx_valid=1
  - otherwise: keep old rx_data, drop the new word, set overrun
  - in the same cycle, reload tx_shadow from tx_data and pulse tx_load. The first sck_fall after the boundary then drives the new word's MSB. SS may stay low for back-to-back words.
- Handshake: rx_valid clears on a cycle with rx_valid && rx_ready, unless a new word loads in that same cycle, in which case it stays 1 with the new data.
- overrun: set by a dropped word; cleared by ovr_clr. If set and ovr_clr occur in the same cycle, set wins.
- Rst mid-frame: return to IDLE immediately and discard the partial word. A later transfer only starts on a fresh ss_fall; SS already low at reset release does not start a frame.

## Timing
- Reset values: MISO=0, SSPIF=0, rx_data=0, rx_valid=0, tx_load=0, overrun=0, busy=0, bit_cnt=0. Synchronizer flops reset to SCK=0, SS=1, MOSI=0.
- Input-to-detect latency: SYNC_STAGES+1 Clk cycles from a pin edge to the internal edge strobe.
- Timing constraints:
  - SCK high and low times must each be at least SYNC_STAGES+2 Clk periods.
  - The SS-low to first SCK rise gap must be at least 2*(SYNC_STAGES+2) Clk periods.
- rx_valid and tx_load assert 1 cycle after the detected final sck_rise of a word. SSPIF asserts 1 cycle after the detected 8th sck_rise of each byte.
- MISO changes 1 cycle after a detected sck_fall or ss_fall.
- Only one sck edge can be detected per Clk cycle; no further pipelining.

## Test plan
- Reset, SS high, no SCK: all outputs 0 and busy=0 for 20 cycles.
- SS low, MOSI 0xA5 then 0x3C (16 SCK), rx_ready=0, tx_data=0x8001: SSPIF pulses twice; rx_data=0xA53C, rx_valid=1; MISO sequence is 1, fourteen 0s, then 1; exactly one tx_load at ss_fall.
- Back-to-back 0x1234 then 0x5678 with SS held low, rx_ready held 0: rx_data stays 0x1234, overrun=1, two tx_load pulses at word boundaries. Pulsing ovr_clr then clears overrun.
- Same sequence, but rx_ready=1 in the exact cycle the second word completes: rx_data=0x5678, rx_valid stays 1, overrun=0.
- SS raised after 11 bits, then a full 0xBEEF frame: after the abort, rx_valid=0 and exactly one SSPIF has pulsed. The next frame gives rx_data=0xBEEF.
- Rst asserted mid-word at bit 5, then released with SS still low: outputs 0, no capture until SS rises and falls again, then a normal frame of 0x00FF gives rx_data=0x00FF.
